reg_status_table: RTL and testbench
===================================

// Module: reg_status_table
// PURPOSE
// - Register status (rename) table beside the register file in the out-of-order core.
// - Per architectural register it holds a busy bit and the ROB tag of the youngest in-flight writer.
// - At issue, it reports per source operand (rs1/rs2) whether the RS takes the value from the register file or waits on a ROB tag.
// - At commit, it releases the register so later reads use the register-file value.
// PARAMETERS
// - TAG_W  4   width of a ROB tag (ROB depth = 2**TAG_W)
// - NREG   32  architectural registers; index width fixed at 5
// PORTS
// - clk_in        in   1      clock
// - rst_in        in   1      reset, asynchronous, active-high
// - rdy_in        in   1      global enable; 0 freezes all state and outputs
// - flush_in      in   1      mispredict flush: all registers become not-busy
// - issue_valid   in   1      one instruction issuing this cycle
// - issue_rs1     in   5      source 1 index
// - issue_rs2     in   5      source 2 index
// - issue_has_rd  in   1      instruction writes rd
// - issue_rd      in   5      destination index
// - issue_tag     in   TAG_W  ROB tag allocated to the instruction
// - commit_valid  in   1      ROB commits one instruction this cycle
// - commit_rd     in   5      committed destination index
// - commit_tag    in   TAG_W  ROB tag of the committed instruction
// - out_valid     out  1      lookup result valid (1 cycle after issue)
// - out_q1_busy   out  1      rs1 pending; wait on out_q1_tag
// - out_q1_tag    out  TAG_W  producer tag for rs1 (0 when not busy)
// - out_q2_busy   out  1      rs2 pending
// - out_q2_tag    out  TAG_W  producer tag for rs2 (0 when not busy)
// BEHAVIOUR
// - Reset: all busy=0, all tags=0; out_valid=0, out_q*_busy=0, out_q*_tag=0.
// - Latency: the lookup is registered. Results appear one edge after issue_valid, in the same cycle as the register file's operand outputs.
// - out_valid is a one-cycle pulse per accepted issue.
// - Lookup order within one cycle:
//   - the commit is applied first: the lookup sees the register released if commit_rd matches and commit_tag equals the stored tag;
//   - then the sources are read;
//   - then the issuing rd is marked. rs1==rd or rs2==rd therefore reports the OLD status, never its own tag.
// - Commit clears busy[commit_rd] only if busy and tag[commit_rd]==commit_tag. A stale commit (a younger writer was renamed) leaves the entry untouched.
// - Issue with issue_has_rd=1 and rd!=0: busy[rd]<=1, tag[rd]<=issue_tag.
// - Commit and issue to the same rd in one cycle: issue wins; the entry ends busy with issue_tag.
// - x0: never busy; lookups of x0 return busy=0, tag=0; writes to x0 are ignored.
// - flush_in=1 (priority over issue and commit):
//   - all busy<=0; out_valid<=0 next cycle;
//   - an issue in the same cycle is dropped;
//   - tags may retain stale values but are masked by busy=0.
// - rdy_in=0: no state or output changes, including flush. Inputs are ignored.
// - Reset mid-operation clears everything asynchronously. The first post-reset issue sees all registers not-busy.
// - out_q*_tag is forced to 0 whenever the matching busy output is 0.
// STRUCTURE
// - Shared package (cpu_pkg): typedef rob_tag_t (logic [TAG_W-1:0]), typedef reg_idx_t (logic [4:0]), constant REG_ZERO=5'd0.
// - Storage: a flop vector busy[NREG] and a flop array tag[NREG].
// - One sub-module is natural: rst_operand_lookup, a combinational per-source read with commit bypass and x0 masking, instantiated twice.
// - Registered output stage in this module.
// TESTING
// - Reset, issue rs1=1 rs2=2 rd=3 tag=5 -> next cycle out_valid=1, q1/q2 busy=0; a following lookup of rs1=3 -> q1_busy=1, q1_tag=5.
// - x3 busy tag=5; commit rd=3 tag=5 together with an issue reading rs1=3 -> q1_busy=0 (bypass); busy[3]=0 afterwards.
// - x3 tag=5, reissued rd=3 tag=7; commit rd=3 tag=5 -> x3 stays busy with tag 7 (stale commit ignored).
// - Same cycle: commit rd=4 tag=2 (matching) and issue rd=4 tag=9 -> x4 busy tag 9.
// - Issue rs1=6 rd=6 tag=1 with x6 idle -> q1_busy=0. Issue rd=0 tag=3, then read rs1=0 -> busy=0.
// - Mark x1..x5 busy; flush_in=1 together with issue rd=7 -> next cycle out_valid=0, all lookups busy=0.
// - rdy_in=0 for 3 cycles during an issue -> outputs hold and no state change.

Source files
------------

// File: rtl/reg_status_table_pkg.sv
// Shared CPU types for the rename/status logic: ROB tag and register index types.
package reg_status_table_pkg;

    localparam int unsigned TAG_W_DEF = 4;

    typedef logic [TAG_W_DEF-1:0] rob_tag_t;
    typedef logic [4:0]           reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_status_table_operand_lookup.sv
// Combinational per-source status read with same-cycle commit bypass and x0 masking.
module rst_operand_lookup
    import reg_status_table_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NREG  = 32
) (
    input  logic [NREG-1:0]            i_busy,
    input  logic [NREG-1:0][TAG_W-1:0] i_tag,
    input  reg_idx_t                   i_rs,
    input  logic                       i_commit_valid,
    input  reg_idx_t                   i_commit_rd,
    input  logic [TAG_W-1:0]           i_commit_tag,
    output logic                       o_busy,
    output logic [TAG_W-1:0]           o_tag
);

    logic w_released;

    // A matching commit this cycle releases the entry before it is read.
    assign w_released = i_commit_valid && (i_commit_rd == i_rs) &&
                        (i_tag[i_rs] == i_commit_tag);

    always_comb begin
        o_busy = (i_rs != REG_ZERO) && i_busy[i_rs] && !w_released;
        o_tag  = o_busy ? i_tag[i_rs] : '0;
    end

endmodule

// File: rtl/reg_status_table.sv
// Register status (rename) table: per-register busy bit and youngest-writer ROB tag,
// with a registered per-source lookup for the issuing instruction.
module reg_status_table
    import reg_status_table_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NREG  = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             issue_valid,
    input  reg_idx_t         issue_rs1,
    input  reg_idx_t         issue_rs2,
    input  logic             issue_has_rd,
    input  reg_idx_t         issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             commit_valid,
    input  reg_idx_t         commit_rd,
    input  logic [TAG_W-1:0] commit_tag,
    output logic             out_valid,
    output logic             out_q1_busy,
    output logic [TAG_W-1:0] out_q1_tag,
    output logic             out_q2_busy,
    output logic [TAG_W-1:0] out_q2_tag
);

    logic [NREG-1:0]            r_busy;
    logic [NREG-1:0][TAG_W-1:0] r_tag;

    logic             w_q1_busy;
    logic [TAG_W-1:0] w_q1_tag;
    logic             w_q2_busy;
    logic [TAG_W-1:0] w_q2_tag;
    logic             w_commit_hit;
    logic             w_issue_wr;

    rst_operand_lookup #(.TAG_W(TAG_W), .NREG(NREG)) u_lookup_rs1 (
        .i_busy         (r_busy),
        .i_tag          (r_tag),
        .i_rs           (issue_rs1),
        .i_commit_valid (commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_tag   (commit_tag),
        .o_busy         (w_q1_busy),
        .o_tag          (w_q1_tag)
    );

    rst_operand_lookup #(.TAG_W(TAG_W), .NREG(NREG)) u_lookup_rs2 (
        .i_busy         (r_busy),
        .i_tag          (r_tag),
        .i_rs           (issue_rs2),
        .i_commit_valid (commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_tag   (commit_tag),
        .o_busy         (w_q2_busy),
        .o_tag          (w_q2_tag)
    );

    assign w_commit_hit = commit_valid && r_busy[commit_rd] &&
                          (r_tag[commit_rd] == commit_tag);
    assign w_issue_wr   = issue_valid && issue_has_rd && (issue_rd != REG_ZERO);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy      <= '0;
            r_tag       <= '0;
            out_valid   <= 1'b0;
            out_q1_busy <= 1'b0;
            out_q1_tag  <= '0;
            out_q2_busy <= 1'b0;
            out_q2_tag  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy      <= '0;
                out_valid   <= 1'b0;
                out_q1_busy <= 1'b0;
                out_q1_tag  <= '0;
                out_q2_busy <= 1'b0;
                out_q2_tag  <= '0;
            end else begin
                // Issue is written after commit so it wins on a shared rd.
                if (w_commit_hit) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_issue_wr) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_tag[issue_rd]  <= issue_tag;
                end
                out_valid   <= issue_valid;
                out_q1_busy <= issue_valid && w_q1_busy;
                out_q1_tag  <= issue_valid ? w_q1_tag : '0;
                out_q2_busy <= issue_valid && w_q2_busy;
                out_q2_tag  <= issue_valid ? w_q2_tag : '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Directed self-checking bench for reg_status_table with hand-computed expectations.
module tb_reg_status_table;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic       flush_in;
    logic       issue_valid;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_has_rd;
    logic [4:0] issue_rd;
    logic [3:0] issue_tag;
    logic       commit_valid;
    logic [4:0] commit_rd;
    logic [3:0] commit_tag;
    logic       out_valid;
    logic       out_q1_busy;
    logic [3:0] out_q1_tag;
    logic       out_q2_busy;
    logic [3:0] out_q2_tag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_in = ~clk_in;

    reg_status_table #(.TAG_W(4), .NREG(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_has_rd (issue_has_rd),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .out_valid    (out_valid),
        .out_q1_busy  (out_q1_busy),
        .out_q1_tag   (out_q1_tag),
        .out_q2_busy  (out_q2_busy),
        .out_q2_tag   (out_q2_tag)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        flush_in     = 1'b0;
        issue_valid  = 1'b0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_has_rd = 1'b0;
        issue_rd     = '0;
        issue_tag    = '0;
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_tag   = '0;
    endtask

    task automatic set_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic has_rd, input logic [4:0] rd, input logic [3:0] tag);
        issue_valid  = 1'b1;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        issue_has_rd = has_rd;
        issue_rd     = rd;
        issue_tag    = tag;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [3:0] tag);
        commit_valid = 1'b1;
        commit_rd    = rd;
        commit_tag   = tag;
    endtask

    // Advance one edge, sample 1ns later, then return inputs to idle.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic step_clear();
        step();
        clear_inputs();
    endtask

    task automatic check_q(input string tag, input logic v, input logic b1, input logic [3:0] t1,
                           input logic b2, input logic [3:0] t2);
        check_val({tag, "_valid"}, {31'd0, out_valid},   {31'd0, v});
        check_val({tag, "_q1b"},   {31'd0, out_q1_busy}, {31'd0, b1});
        check_val({tag, "_q1t"},   {28'd0, out_q1_tag},  {28'd0, t1});
        check_val({tag, "_q2b"},   {31'd0, out_q2_busy}, {31'd0, b2});
        check_val({tag, "_q2t"},   {28'd0, out_q2_tag},  {28'd0, t2});
    endtask

    initial begin
        clear_inputs();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        #12;
        check_q("reset", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Basic issue and follow-up lookup of the renamed register.
        @(negedge clk_in);
        set_issue(5'd1, 5'd2, 1'b1, 5'd3, 4'd5);
        step_clear();
        check_q("iss1", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        set_issue(5'd3, 5'd0, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("rd_x3", 1'b1, 1'b1, 4'd5, 1'b0, 4'd0);

        // Commit bypass into a same-cycle lookup.
        set_issue(5'd3, 5'd0, 1'b0, 5'd0, 4'd0);
        set_commit(5'd3, 4'd5);
        step_clear();
        check_q("bypass", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        set_issue(5'd3, 5'd3, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("after_commit", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);

        // Stale commit against a younger writer.
        set_issue(5'd0, 5'd0, 1'b1, 5'd3, 4'd5);
        step_clear();
        set_issue(5'd0, 5'd0, 1'b1, 5'd3, 4'd7);
        step_clear();
        set_commit(5'd3, 4'd5);
        step_clear();
        check_val("pulse_low", {31'd0, out_valid}, 32'd0);
        set_issue(5'd3, 5'd0, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("stale", 1'b1, 1'b1, 4'd7, 1'b0, 4'd0);

        // Commit and issue to the same rd: issue wins; lookup sees the release.
        set_issue(5'd0, 5'd0, 1'b1, 5'd4, 4'd2);
        step_clear();
        set_issue(5'd4, 5'd0, 1'b1, 5'd4, 4'd9);
        set_commit(5'd4, 4'd2);
        step_clear();
        check_q("same_rd", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        set_issue(5'd4, 5'd4, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("x4_tag9", 1'b1, 1'b1, 4'd9, 1'b1, 4'd9);

        // Self-dependence reports old status; x0 writes ignored.
        set_issue(5'd6, 5'd0, 1'b1, 5'd6, 4'd1);
        step_clear();
        check_q("self_dep", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        set_issue(5'd0, 5'd0, 1'b1, 5'd0, 4'd3);
        step_clear();
        set_issue(5'd0, 5'd6, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("x0", 1'b1, 1'b0, 4'd0, 1'b1, 4'd1);

        // Flush with a concurrent issue: issue dropped, everything idle.
        for (int unsigned r = 1; r <= 5; r++) begin
            set_issue(5'd0, 5'd0, 1'b1, 5'(r), 4'(r + 8));
            step_clear();
        end
        set_issue(5'd1, 5'd2, 1'b1, 5'd7, 4'd6);
        flush_in = 1'b1;
        step_clear();
        check_val("flush_valid", {31'd0, out_valid}, 32'd0);
        for (int unsigned r = 1; r <= 7; r++) begin
            set_issue(5'(r), 5'(r), 1'b0, 5'd0, 4'd0);
            step_clear();
            check_q($sformatf("flushed_x%0d", r), 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        end

        // rdy_in low freezes outputs and state, flush included.
        set_issue(5'd0, 5'd0, 1'b1, 5'd9, 4'd12);
        step_clear();
        set_issue(5'd9, 5'd0, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("pre_stall", 1'b1, 1'b1, 4'd12, 1'b0, 4'd0);
        rdy_in = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            set_issue(5'd0, 5'd0, 1'b1, 5'd9, 4'd3);
            set_commit(5'd9, 4'd12);
            flush_in = 1'b1;
            step_clear();
            check_q($sformatf("stall%0d", c), 1'b1, 1'b1, 4'd12, 1'b0, 4'd0);
        end
        rdy_in = 1'b1;
        set_issue(5'd9, 5'd0, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("post_stall", 1'b1, 1'b1, 4'd12, 1'b0, 4'd0);

        // Asynchronous reset mid-operation.
        set_issue(5'd9, 5'd0, 1'b0, 5'd0, 4'd0);
        step();
        #2;
        rst_in = 1'b1;
        #1;
        check_q("async_rst", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        set_issue(5'd9, 5'd3, 1'b0, 5'd0, 4'd0);
        step_clear();
        check_q("post_rst", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
